// File: rtl/input_queue.sv
// input_queue: CPU input front end, the counterpart of the PC/SP display path.
// A raw push-button is synchronized and debounced. Each confirmed press captures
// the synchronized switch bank into a small FIFO, which the CPU drains one entry
// per rd_en pulse. The head entry is always presented on rd_data (show-ahead).
//
// Ports:
//   clk      - system clock, all state lives here
//   rst_n    - asynchronous active-low reset
//   btn_n    - raw push-button, active-low, asynchronous
//   sw       - raw switch bank [IN_WIDTH], asynchronous
//   rd_en    - single-cycle pop request
//   ovf_clr  - clears the sticky overflow flag
//   rd_data  - head entry, zero when empty [DATA_WIDTH]
//   empty    - FIFO holds no entries
//   full     - FIFO holds 2**DEPTH_LOG2 entries
//   count    - number of stored entries [DEPTH_LOG2+1]
//   overflow - sticky, a press was dropped while full
//   press    - one-cycle pulse per accepted press
module input_queue #(
  parameter int IN_WIDTH        = 4,
  parameter int DATA_WIDTH      = 16,
  parameter int DEPTH_LOG2      = 3,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_n,
  input  logic [IN_WIDTH-1:0]   sw,
  input  logic                  rd_en,
  input  logic                  ovf_clr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  press
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]      DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      DB_ONE    = CNT_W'(1'b1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1'b1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1'b1);
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  // Synchronizers (button idles released = 1)
  logic                  r_btn_s1, r_btn_s2;
  logic [IN_WIDTH-1:0]   r_sw_s1, r_sw_s2;
  // Debounce state: r_db_btn uses btn_n polarity (1 = released)
  logic                  r_db_btn;
  logic [CNT_W-1:0]      r_db_cnt;
  logic                  r_press;
  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_empty, r_full, r_overflow;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic                  w_differ, w_settle, w_press_evt;
  logic                  w_push, w_pop, w_drop;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DEPTH_LOG2-1:0] w_rd_ptr_next;
  logic [DEPTH_LOG2:0]   w_count_next;
  logic [DATA_WIDTH-1:0] w_head_next;

  // Two-flop synchronizers for the button and switch bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_s1 <= 1'b1;
      r_btn_s2 <= 1'b1;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_btn_s1 <= btn_n;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= sw;
      r_sw_s2  <= r_sw_s1;
    end
  end

  // Debounce decode: a level change is accepted after DEBOUNCE_CYCLES
  // consecutive differing samples; only the released->pressed flip is a press.
  always_comb begin
    w_differ    = r_btn_s2 ^ r_db_btn;
    w_settle    = w_differ && (r_db_cnt == DB_LAST);
    w_press_evt = w_settle && !r_btn_s2;
  end

  // Debounce counter, debounced level and the registered press pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_btn <= 1'b1;
      r_db_cnt <= '0;
      r_press  <= 1'b0;
    end else begin
      r_press <= w_press_evt;
      if (!w_differ) begin
        r_db_cnt <= '0;
      end else if (w_settle) begin
        r_db_btn <= r_btn_s2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_ONE;
      end
    end
  end

  // FIFO control. A push into a full FIFO is only legal when a pop frees a
  // slot in the same cycle. The next head is computed here so rd_data can be
  // a register: it bypasses the write when the pushed slot becomes the head.
  always_comb begin
    w_push  = r_press && (!r_full || rd_en);
    w_pop   = rd_en && !r_empty;
    w_drop  = r_press && r_full && !rd_en;
    w_wdata = DATA_WIDTH'(r_sw_s2);
    if (w_pop) begin
      w_rd_ptr_next = r_rd_ptr + PTR_ONE;
    end else begin
      w_rd_ptr_next = r_rd_ptr;
    end
    if (w_push && !w_pop) begin
      w_count_next = r_count + CNT_ONE;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CNT_ONE;
    end else begin
      w_count_next = r_count;
    end
    if (w_count_next == '0) begin
      w_head_next = '0;
    end else if (w_push && (r_wr_ptr == w_rd_ptr_next)) begin
      w_head_next = w_wdata;
    end else begin
      w_head_next = r_mem[w_rd_ptr_next];
    end
  end

  // FIFO storage, pointers, status flags and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_wdata;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      r_rd_ptr  <= w_rd_ptr_next;
      r_count   <= w_count_next;
      r_empty   <= (w_count_next == '0);
      r_full    <= (w_count_next == DEPTH_CNT);
      r_rd_data <= w_head_next;
      // Set wins over clear so a coincident drop is never lost
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign empty    = r_empty;
  assign full     = r_full;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign press    = r_press;

endmodule
